pulse_reg_queue: RTL and testbench
==================================

Name: pulse_reg_queue

Overview:
- Parametrised successor to the single-entry pulse register.
- Builds each pulse parameter word in a sticky staging register. Each field is loaded either from the command immediate or from the processor register, under per-field enable/select bits.
- On command strobe, the staged word goes either straight to the output (direct mode) or into a DEPTH-entry FIFO. Queued words are released to the DAC/element path one per release_in trigger.
- Sits between the distributed-processor core and the pulse_iface consumer.
- Adds status for fill level, overflow and underflow.

Parameters:
DATA_WIDTH, 32, processor register width (reg_in)
ENV_WIDTH, 24, envelope word width
PHASE_WIDTH, 17, phase width
FREQ_WIDTH, 9, frequency index width
AMP_WIDTH, 16, amplitude width
CFG_WIDTH, 4, config width
DEPTH, 4, queue entries (power of 2, >=2)
CMD_WIDTH, PHASE_WIDTH+FREQ_WIDTH+ENV_WIDTH+AMP_WIDTH+CFG_WIDTH+9, derived command width
LVL_WIDTH, $clog2(DEPTH+1), derived fill-level width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pulse_cmd_in  in  CMD_WIDTH  field immediates plus control bits
reg_in  in  DATA_WIDTH  register-sourced field value
pulse_write_en  in  1  apply pulse_cmd_in to staging
cstrobe_in  in  1  commit staged word (push or direct)
queue_mode  in  1  1=queued, 0=direct
release_in  in  1  pop head to output (queued mode)
clear_flags  in  1  clear sticky flags
env_word  out  ENV_WIDTH  output envelope
phase  out  PHASE_WIDTH  output phase
freq  out  FREQ_WIDTH  output frequency
amp  out  AMP_WIDTH  output amplitude
cfg  out  CFG_WIDTH  output config
cstrobe_out  out  1  one-cycle strobe, new output word valid
fill_level  out  LVL_WIDTH  occupied entries
full  out  1  fill_level==DEPTH
empty  out  1  fill_level==0
overflow  out  1  sticky: push dropped
underflow  out  1  sticky: release on empty

Behaviour:
- Command layout, LSB first:
  - phase, freq, env, amp, cfg immediates;
  - then phase_sel, phase_en, freq_sel, freq_en, env_sel, env_en, amp_sel, amp_en, cfg_en.
- Staging update on pulse_write_en:
  - Each field with en=1 loads reg_in[FIELD_W-1:0] if sel=1, else its immediate.
  - If FIELD_W > DATA_WIDTH, the reg_in value is zero-extended.
  - cfg is always loaded from its immediate.
  - Fields with en=0 hold (sticky).
- Commit word = staging merged with the same-cycle write. If pulse_write_en and cstrobe_in occur together, the committed word includes that write.
- Direct mode (queue_mode=0):
  - cstrobe_in at cycle t → outputs load the commit word and cstrobe_out=1 at t+1.
  - FIFO is untouched; release_in is ignored.
- Queued mode, push: cstrobe_in pushes the commit word. The entry is poppable from t+1.
- Queued mode, release: release_in at t with empty=0 → outputs load the head, cstrobe_out=1 at t+1, and the entry is popped.
- Queued mode, full and empty cases:
  - Push while full with no same-cycle pop: word dropped, overflow set, level unchanged.
  - Push and pop in the same cycle while full: both occur.
  - Release while empty: underflow set, outputs hold, no strobe. A simultaneous push still enqueues.
- Outputs hold their last value between strobes. cstrobe_out is never high for two consecutive cycles unless triggers are consecutive.
- Pointers wrap modulo DEPTH.
- Changing queue_mode with entries present is legal: entries are retained and released when queued mode resumes.
- clear_flags clears overflow/underflow. A same-cycle setting event wins.
- Reset (synchronous): staging, outputs, pointers, level, flags = 0; cstrobe_out=0; empty=1. Reset mid-queue discards all entries.

Decomposition:
- Package pulse_reg_pkg:
  - field-width localparams;
  - packed struct pulse_word_t {cfg, amp, env, freq, phase};
  - command control-bit offset constants;
  - function unpacking pulse_cmd_in into immediates and control bits.
- Sub-module pulse_word_fifo: sync FIFO of pulse_word_t with push/pop/level/full/empty. Drop-on-full and flag logic stay in the parent.
- Top instantiates pulse_iface internally for its drive, or exposes flat ports as listed.

Test Plan:
- Reset, then direct mode: write phase imm 0x1ABCD and amp from reg_in=0x00012345 with cstrobe → next cycle phase=0x1ABCD, amp=0x2345, cstrobe_out=1 for one cycle.
- Sticky staging: write only freq=0x55, then cstrobe → phase/amp keep 0x1ABCD/0x2345, freq=0x55.
- Queued mode: push 4 words with amp=1,2,3,4 → full=1, level=4. A 5th push gives overflow=1, level=4. Four releases emit amp 1,2,3,4 in order, then empty=1.
- Release on empty → underflow=1, no cstrobe_out, outputs unchanged. clear_flags → underflow=0.
- Full with simultaneous push(amp=9) and release → amp=1 emitted, level stays 4, overflow=0. Amp=9 emerges last.
- Reset asserted with 3 queued entries → level=0, outputs 0. A subsequent release sets underflow.

Source files
------------

// File: rtl/pulse_reg_pkg.sv
// Shared widths, pulse word layout and command control-bit offsets
// for the pulse register queue.
package pulse_reg_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ENV_WIDTH   = 24;
    localparam int DEF_PHASE_WIDTH = 17;
    localparam int DEF_FREQ_WIDTH  = 9;
    localparam int DEF_AMP_WIDTH   = 16;
    localparam int DEF_CFG_WIDTH   = 4;
    localparam int DEF_DEPTH       = 4;

    // control bits, relative to the end of the immediates
    localparam int PHASE_SEL = 0;
    localparam int PHASE_EN  = 1;
    localparam int FREQ_SEL  = 2;
    localparam int FREQ_EN   = 3;
    localparam int ENV_SEL   = 4;
    localparam int ENV_EN    = 5;
    localparam int AMP_SEL   = 6;
    localparam int AMP_EN    = 7;
    localparam int CFG_EN    = 8;
    localparam int CTL_BITS  = 9;

    typedef struct packed {
        logic [DEF_CFG_WIDTH-1:0]   cfg;
        logic [DEF_AMP_WIDTH-1:0]   amp;
        logic [DEF_ENV_WIDTH-1:0]   env;
        logic [DEF_FREQ_WIDTH-1:0]  freq;
        logic [DEF_PHASE_WIDTH-1:0] phase;
    } pulse_word_t;

    function automatic int ctl_base(
        input int pw,
        input int fw,
        input int ew,
        input int aw,
        input int cw
    );
        return pw + fw + ew + aw + cw;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_word_fifo.sv
// Synchronous pulse-word FIFO; the parent guarantees push is legal
// (not full, or a same-cycle pop) and pop only when not empty.
module pulse_word_fifo #(
    parameter int WIDTH     = 70,
    parameter int DEPTH     = 4,
    parameter int LVL_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic [LVL_WIDTH-1:0] level,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    // power-of-two depth: pointers wrap by overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LVL_WIDTH'(1);
                2'b01:   level <= level - LVL_WIDTH'(1);
                default: level <= level;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign full  = (level == LVL_WIDTH'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/pulse_reg_queue.sv
// Pulse parameter staging register with direct or queued release
// toward the pulse interface, plus fill/overflow/underflow status.
module pulse_reg_queue
    import pulse_reg_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ENV_WIDTH   = DEF_ENV_WIDTH,
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int FREQ_WIDTH  = DEF_FREQ_WIDTH,
    parameter int AMP_WIDTH   = DEF_AMP_WIDTH,
    parameter int CFG_WIDTH   = DEF_CFG_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int CMD_WIDTH   = PHASE_WIDTH + FREQ_WIDTH + ENV_WIDTH
                              + AMP_WIDTH + CFG_WIDTH + 9,
    parameter int LVL_WIDTH   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CMD_WIDTH-1:0]   pulse_cmd_in,
    input  logic [DATA_WIDTH-1:0]  reg_in,
    input  logic                   pulse_write_en,
    input  logic                   cstrobe_in,
    input  logic                   queue_mode,
    input  logic                   release_in,
    input  logic                   clear_flags,
    output logic [ENV_WIDTH-1:0]   env_word,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic [FREQ_WIDTH-1:0]  freq,
    output logic [AMP_WIDTH-1:0]   amp,
    output logic [CFG_WIDTH-1:0]   cfg,
    output logic                   cstrobe_out,
    output logic [LVL_WIDTH-1:0]   fill_level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int FO = PHASE_WIDTH;
    localparam int EO = FO + FREQ_WIDTH;
    localparam int AO = EO + ENV_WIDTH;
    localparam int CO = AO + AMP_WIDTH;
    localparam int CB = ctl_base(PHASE_WIDTH, FREQ_WIDTH,
                                 ENV_WIDTH, AMP_WIDTH, CFG_WIDTH);
    localparam int WORD_W = CB;
    localparam int FMAX = max2(max2(PHASE_WIDTH, FREQ_WIDTH),
                               max2(ENV_WIDTH, AMP_WIDTH));
    localparam int EXT = max2(FMAX, DATA_WIDTH);

    logic [CTL_BITS-1:0] ctl;
    logic [EXT-1:0]      reg_x;
    logic                unused_reg_hi;

    // register source, zero-extended for fields wider than reg_in
    assign ctl           = pulse_cmd_in[CB +: CTL_BITS];
    assign reg_x         = EXT'(reg_in);
    assign unused_reg_hi = ^reg_x;

    logic [PHASE_WIDTH-1:0] stg_phase, nxt_phase;
    logic [FREQ_WIDTH-1:0]  stg_freq,  nxt_freq;
    logic [ENV_WIDTH-1:0]   stg_env,   nxt_env;
    logic [AMP_WIDTH-1:0]   stg_amp,   nxt_amp;
    logic [CFG_WIDTH-1:0]   stg_cfg,   nxt_cfg;

    always_comb begin
        nxt_phase = stg_phase;
        nxt_freq  = stg_freq;
        nxt_env   = stg_env;
        nxt_amp   = stg_amp;
        nxt_cfg   = stg_cfg;
        if (pulse_write_en) begin
            if (ctl[PHASE_EN]) begin
                nxt_phase = ctl[PHASE_SEL]
                          ? reg_x[PHASE_WIDTH-1:0]
                          : pulse_cmd_in[FO-1:0];
            end
            if (ctl[FREQ_EN]) begin
                nxt_freq = ctl[FREQ_SEL]
                         ? reg_x[FREQ_WIDTH-1:0]
                         : pulse_cmd_in[EO-1:FO];
            end
            if (ctl[ENV_EN]) begin
                nxt_env = ctl[ENV_SEL]
                        ? reg_x[ENV_WIDTH-1:0]
                        : pulse_cmd_in[AO-1:EO];
            end
            if (ctl[AMP_EN]) begin
                nxt_amp = ctl[AMP_SEL]
                        ? reg_x[AMP_WIDTH-1:0]
                        : pulse_cmd_in[CO-1:AO];
            end
            if (ctl[CFG_EN]) begin
                nxt_cfg = pulse_cmd_in[CB-1:CO];
            end
        end
    end

    logic [WORD_W-1:0] commit_w;
    logic [WORD_W-1:0] head_w;
    logic              f_full;
    logic              f_empty;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              direct_go;
    logic              ovf_set;
    logic              udf_set;

    assign commit_w  = {nxt_cfg, nxt_amp, nxt_env, nxt_freq, nxt_phase};
    assign direct_go = cstrobe_in && !queue_mode;
    assign push_req  = cstrobe_in && queue_mode;
    assign pop       = release_in && queue_mode && !f_empty;
    // a full queue still accepts when the head leaves this cycle
    assign push      = push_req && (!f_full || pop);
    assign ovf_set   = push_req && f_full && !pop;
    assign udf_set   = release_in && queue_mode && f_empty;

    pulse_word_fifo #(
        .WIDTH     (WORD_W),
        .DEPTH     (DEPTH),
        .LVL_WIDTH (LVL_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (commit_w),
        .dout  (head_w),
        .level (fill_level),
        .full  (f_full),
        .empty (f_empty)
    );

    assign full  = f_full;
    assign empty = f_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_phase   <= '0;
            stg_freq    <= '0;
            stg_env     <= '0;
            stg_amp     <= '0;
            stg_cfg     <= '0;
            phase       <= '0;
            freq        <= '0;
            env_word    <= '0;
            amp         <= '0;
            cfg         <= '0;
            cstrobe_out <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (pulse_write_en) begin
                stg_phase <= nxt_phase;
                stg_freq  <= nxt_freq;
                stg_env   <= nxt_env;
                stg_amp   <= nxt_amp;
                stg_cfg   <= nxt_cfg;
            end
            cstrobe_out <= direct_go || pop;
            unique case (1'b1)
                direct_go: begin
                    phase    <= nxt_phase;
                    freq     <= nxt_freq;
                    env_word <= nxt_env;
                    amp      <= nxt_amp;
                    cfg      <= nxt_cfg;
                end
                pop: begin
                    phase    <= head_w[FO-1:0];
                    freq     <= head_w[EO-1:FO];
                    env_word <= head_w[AO-1:EO];
                    amp      <= head_w[CO-1:AO];
                    cfg      <= head_w[CB-1:CO];
                end
                default: ;
            endcase
            // setting event wins over a same-cycle clear
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (clear_flags) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_reg_queue.sv
// Directed scoreboard bench: stimulus pushes expected words, a
// negedge monitor pops and compares on every cstrobe_out.
module tb_pulse_reg_queue;
    import pulse_reg_pkg::*;

    localparam logic [8:0] PH_EN  = 9'h002;
    localparam logic [8:0] FR_EN  = 9'h008;
    localparam logic [8:0] EN_SEL = 9'h010;
    localparam logic [8:0] EN_EN  = 9'h020;
    localparam logic [8:0] AM_SEL = 9'h040;
    localparam logic [8:0] AM_EN  = 9'h080;
    localparam logic [8:0] CF_EN  = 9'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic [78:0] pulse_cmd_in;
    logic [31:0] reg_in;
    logic        pulse_write_en;
    logic        cstrobe_in;
    logic        queue_mode;
    logic        release_in;
    logic        clear_flags;
    logic [23:0] env_word;
    logic [16:0] phase;
    logic [8:0]  freq;
    logic [15:0] amp;
    logic [3:0]  cfg;
    logic        cstrobe_out;
    logic [2:0]  fill_level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;
    pulse_word_t exp_q[$];

    pulse_reg_queue dut (
        .clk            (clk),
        .reset          (reset),
        .pulse_cmd_in   (pulse_cmd_in),
        .reg_in         (reg_in),
        .pulse_write_en (pulse_write_en),
        .cstrobe_in     (cstrobe_in),
        .queue_mode     (queue_mode),
        .release_in     (release_in),
        .clear_flags    (clear_flags),
        .env_word       (env_word),
        .phase          (phase),
        .freq           (freq),
        .amp            (amp),
        .cfg            (cfg),
        .cstrobe_out    (cstrobe_out),
        .fill_level     (fill_level),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [78:0] cmd(
        input logic [16:0] ph,
        input logic [8:0]  fr,
        input logic [23:0] en,
        input logic [15:0] am,
        input logic [3:0]  cf,
        input logic [8:0]  ctl
    );
        return {ctl, cf, am, en, fr, ph};
    endfunction

    function automatic pulse_word_t wd(
        input logic [16:0] ph,
        input logic [8:0]  fr,
        input logic [23:0] en,
        input logic [15:0] am,
        input logic [3:0]  cf
    );
        pulse_word_t w;
        w.phase = ph;
        w.freq  = fr;
        w.env   = en;
        w.amp   = am;
        w.cfg   = cf;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        pulse_write_en = 1'b0;
        cstrobe_in     = 1'b0;
        release_in     = 1'b0;
        clear_flags    = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic push_amp(input logic [15:0] a);
        pulse_cmd_in   = cmd(0, 0, 0, a, 0, AM_EN);
        pulse_write_en = 1'b1;
        cstrobe_in     = 1'b1;
        tick();
    endtask

    task automatic rel(input pulse_word_t w);
        exp_q.push_back(w);
        release_in = 1'b1;
        tick();
    endtask

    // monitor: every strobe must match the oldest expected word
    always @(negedge clk) begin
        if (cstrobe_out === 1'b1) begin
            pulse_word_t got;
            got = {cfg, amp, env_word, freq, phase};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got %0h want none",
                         got);
            end else begin
                pulse_word_t e;
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL out_word: got %0h want %0h", got, e);
                end
            end
        end
    end

    initial begin
        pulse_word_t q;
        reset          = 1'b1;
        pulse_cmd_in   = '0;
        reg_in         = '0;
        pulse_write_en = 1'b0;
        cstrobe_in     = 1'b0;
        queue_mode     = 1'b0;
        release_in     = 1'b0;
        clear_flags    = 1'b0;
        @(posedge clk);
        reset = 1'b1;
        tick();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_level", 32'(fill_level), 0);
        chk("rst_strobe", 32'(cstrobe_out), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_flags", {30'd0, overflow, underflow}, 0);

        // direct: phase immediate, amp from register (truncated)
        reg_in         = 32'h0001_2345;
        pulse_cmd_in   = cmd(17'h1ABCD, 0, 0, 16'h7777, 0,
                             PH_EN | AM_SEL | AM_EN);
        pulse_write_en = 1'b1;
        cstrobe_in     = 1'b1;
        exp_q.push_back(wd(17'h1ABCD, 0, 0, 16'h2345, 0));
        tick();
        chk("direct_strobe", 32'(cstrobe_out), 1);
        chk("direct_amp", 32'(amp), 32'h2345);
        tick();
        chk("direct_strobe_1cyc", 32'(cstrobe_out), 0);
        chk("direct_fifo_level", 32'(fill_level), 0);

        // sticky staging with same-cycle write
        pulse_cmd_in   = cmd(17'h00001, 9'h055, 0, 16'h0001, 0, FR_EN);
        pulse_write_en = 1'b1;
        cstrobe_in     = 1'b1;
        exp_q.push_back(wd(17'h1ABCD, 9'h055, 0, 16'h2345, 0));
        tick();
        chk("sticky_freq", 32'(freq), 32'h55);

        // staged write only, then bare commit
        reg_in         = 32'h00AB_CDEF;
        pulse_cmd_in   = cmd(0, 0, 24'h111111, 0, 4'h5,
                             EN_SEL | EN_EN | CF_EN);
        pulse_write_en = 1'b1;
        tick();
        chk("write_no_strobe", 32'(cstrobe_out), 0);
        chk("write_no_out", 32'(env_word), 0);
        cstrobe_in = 1'b1;
        exp_q.push_back(wd(17'h1ABCD, 9'h055, 24'hABCDEF, 16'h2345,
                           4'h5));
        tick();
        tick();

        // queued: fill, overflow, drain in order
        queue_mode = 1'b1;
        for (int k = 1; k <= 4; k++) push_amp(16'(k));
        chk("q_full", 32'(full), 1);
        chk("q_level4", 32'(fill_level), 4);
        chk("q_no_strobe_push", 32'(cstrobe_out), 0);
        push_amp(16'd5);
        chk("q_overflow", 32'(overflow), 1);
        chk("q_level_ovf", 32'(fill_level), 4);
        for (int k = 1; k <= 4; k++) begin
            rel(wd(17'h1ABCD, 9'h055, 24'hABCDEF, 16'(k), 4'h5));
        end
        chk("q_empty", 32'(empty), 1);
        chk("q_level0", 32'(fill_level), 0);

        // release on empty
        release_in = 1'b1;
        tick();
        chk("udf_set", 32'(underflow), 1);
        chk("udf_no_strobe", 32'(cstrobe_out), 0);
        chk("udf_hold_amp", 32'(amp), 4);
        clear_flags = 1'b1;
        tick();
        chk("clr_flags", {30'd0, overflow, underflow}, 0);

        // full with simultaneous push and release
        for (int k = 1; k <= 4; k++) push_amp(16'(k));
        pulse_cmd_in   = cmd(0, 0, 0, 16'd9, 0, AM_EN);
        pulse_write_en = 1'b1;
        cstrobe_in     = 1'b1;
        rel(wd(17'h1ABCD, 9'h055, 24'hABCDEF, 16'd1, 4'h5));
        chk("pp_level", 32'(fill_level), 4);
        chk("pp_no_ovf", 32'(overflow), 0);
        for (int k = 2; k <= 5; k++) begin
            q = wd(17'h1ABCD, 9'h055, 24'hABCDEF,
                   (k == 5) ? 16'd9 : 16'(k), 4'h5);
            rel(q);
        end
        chk("pp_empty", 32'(empty), 1);

        // reset mid-queue discards entries
        for (int k = 6; k <= 8; k++) push_amp(16'(k));
        chk("pre_rst_level", 32'(fill_level), 3);
        reset = 1'b1;
        tick();
        chk("mid_rst_level", 32'(fill_level), 0);
        chk("mid_rst_amp", 32'(amp), 0);
        chk("mid_rst_phase", 32'(phase), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        release_in = 1'b1;
        tick();
        chk("post_rst_udf", 32'(underflow), 1);
        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
